// File: rtl/seq_mult_param.sv
// rtl/seq_mult_param.sv - parametrised sequential shift-add multiplier, signed/unsigned per operation
module seq_mult_param #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               signed_mode,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [2*WIDTH-1:0] p,
   output logic               busy,
   output logic               done
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t             state, state_nxt;
   logic [WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]   mplier;
   logic [2*WIDTH-1:0] acc;
   logic [CW-1:0]      cnt;
   logic               neg;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [2*WIDTH-1:0] addend;

   // Operand magnitudes; -2^(WIDTH-1) negates to itself, which reads correctly as unsigned
   always_comb begin
      a_mag  = (signed_mode && a[WIDTH-1]) ? -a : a;
      b_mag  = (signed_mode && b[WIDTH-1]) ? -b : b;
      addend = {{WIDTH{1'b0}}, mcand} << cnt;
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state decode; busy is a pure decode of RUN/FIX
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      case (state)
         IDLE: if (start) state_nxt = RUN;
         RUN: begin
            busy = 1'b1;
            if (cnt == CW'(WIDTH - 1)) state_nxt = FIX;
         end
         FIX: begin
            busy      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: latch operands on accept, one add/shift per RUN edge, sign fix and publish on FIX
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
         neg    <= 1'b0;
         p      <= '0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  mcand  <= a_mag;
                  mplier <= b_mag;
                  neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                  acc    <= '0;
                  cnt    <= '0;
               end
            end
            RUN: begin
               if (mplier[0]) acc <= acc + addend;
               mplier <= mplier >> 1;
               cnt    <= cnt + CW'(1);
            end
            FIX: begin
               p    <= neg ? -acc : acc;
               done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_mult_param.sv
// tb/tb_seq_mult_param.sv - directed self-checking bench for seq_mult_param
module tb_seq_mult_param;

   logic        clk;
   logic        rst;
   logic        start4, smode4, busy4, done4;
   logic [3:0]  a4, b4;
   logic [7:0]  p4;
   logic        start8, smode8, busy8, done8;
   logic [7:0]  a8, b8;
   logic [15:0] p8;
   logic [15:0] prev8;
   int          nchk;
   int          nfail;

   typedef struct {
      logic        sm;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs [10];

   seq_mult_param #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .signed_mode(smode4),
      .a(a4), .b(b4), .p(p4), .busy(busy4), .done(done4)
   );

   seq_mult_param #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .signed_mode(smode8),
      .a(a8), .b(b8), .p(p8), .busy(busy8), .done(done8)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Starts one WIDTH=8 op from the current cycle (#1 after an edge) and waits for done.
   // inject_at > 0 drives a competing start for one cycle after RUN edge inject_at.
   task automatic run_op8(input string nm, input logic sm, input logic [7:0] aa,
                          input logic [7:0] bb, input logic [15:0] exp, input int inject_at);
      int   n;
      logic seen;
      logic hold_ok;
      start8 = 1'b1; smode8 = sm; a8 = aa; b8 = bb;
      @(posedge clk); #1;
      start8  = 1'b0;
      n       = 0;
      seen    = 1'b0;
      hold_ok = (p8 == prev8) && busy8 && !done8;
      while (!seen && n < 20) begin
         if (inject_at > 0 && n == inject_at) begin
            start8 = 1'b1; smode8 = 1'b0; a8 = 8'd3; b8 = 8'd3;
         end
         @(posedge clk); #1;
         start8 = 1'b0;
         n++;
         if (done8) seen = 1'b1;
         else if (!(busy8 && !done8 && p8 == prev8)) hold_ok = 1'b0;
      end
      check({nm, " latency"}, n, 9);
      check({nm, " p"}, p8, exp);
      check({nm, " busy at done"}, busy8, 0);
      check({nm, " hold/busy during run"}, hold_ok, 1);
      prev8 = exp;
   endtask

   initial begin
      int   n, bc, dc;
      logic seen;
      nchk = 0; nfail = 0; prev8 = '0;
      rst = 1'b1;
      start4 = 0; smode4 = 0; a4 = '0; b4 = '0;
      start8 = 0; smode8 = 0; a8 = '0; b8 = '0;

      vecs[0] = '{1'b1, 8'h80, 8'h80, 16'h4000};
      vecs[1] = '{1'b1, 8'h80, 8'h7F, 16'hC080};
      vecs[2] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
      vecs[3] = '{1'b1, 8'hFF, 8'h01, 16'hFFFF};
      vecs[4] = '{1'b1, 8'h00, 8'h5A, 16'h0000};
      vecs[5] = '{1'b1, 8'h7F, 8'h7F, 16'h3F01};
      vecs[6] = '{1'b1, 8'h80, 8'h01, 16'hFF80};
      vecs[7] = '{1'b1, 8'hFE, 8'h03, 16'hFFFA};
      vecs[8] = '{1'b0, 8'h80, 8'h02, 16'h0100};
      vecs[9] = '{1'b0, 8'h02, 8'h09, 16'h0012};

      repeat (2) @(posedge clk);
      #1;
      check("reset p8", p8, 0);
      check("reset busy8", busy8, 0);
      check("reset done8", done8, 0);
      check("reset p4", p4, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // WIDTH=4 unsigned 10*3
      start4 = 1'b1; smode4 = 1'b0; a4 = 4'b1010; b4 = 4'b0011;
      @(posedge clk); #1;
      start4 = 1'b0;
      bc = busy4 ? 1 : 0;
      n = 0; seen = 1'b0;
      while (!seen && n < 20) begin
         @(posedge clk); #1;
         n++;
         if (done4) seen = 1'b1;
         else if (busy4) bc++;
      end
      check("w4 latency", n, 5);
      check("w4 busy cycles", bc, 5);
      check("w4 p", p4, 8'h1E);
      check("w4 busy at done", busy4, 0);
      @(posedge clk); #1;
      check("w4 done one cycle", done4, 0);

      // Table of WIDTH=8 ops, each started in the previous done cycle
      for (int i = 0; i < 10; i++)
         run_op8($sformatf("vec%0d", i), vecs[i].sm, vecs[i].a, vecs[i].b, vecs[i].exp, 0);

      // Competing start during RUN is ignored; exactly one done follows
      run_op8("midop", 1'b0, 8'd5, 8'd7, 16'd35, 3);
      dc = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done8) dc++;
      end
      check("midop extra done", dc, 0);
      check("midop p held", p8, 16'd35);

      // Asynchronous reset mid-operation
      start8 = 1'b1; smode8 = 1'b0; a8 = 8'd5; b8 = 8'd7;
      @(posedge clk); #1;
      start8 = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("async rst p8", p8, 0);
      check("async rst busy8", busy8, 0);
      check("async rst done8", done8, 0);
      @(posedge clk); #2;
      rst = 1'b0;
      prev8 = '0;
      dc = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done8) dc++;
      end
      check("done after rst", dc, 0);
      run_op8("post rst", 1'b0, 8'd5, 8'd7, 16'd35, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule

// File: doc/seq_mult_param.md
# seq_mult_param

Parametrised sequential shift-add multiplier. It is the next generation of the team's fixed 4-bit sequential multiplier: operand width is a parameter, signed (two's complement) and unsigned modes are selected per operation, and a busy flag is provided. It computes one product per start handshake over WIDTH+1 clock cycles, so one adder can be shared across cycles wherever a full combinational multiplier is too large.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- signed_mode  in  1  1 = a, b and p are two's complement; 0 = unsigned; sampled with start
- a  in  WIDTH  multiplicand; sampled with start
- b  in  WIDTH  multiplier; sampled with start
- p  out  2*WIDTH  registered product; holds the last completed result
- busy  out  1  high while an operation is in progress (RUN or FIX)
- done  out  1  registered one-cycle pulse marking that p has just been updated

## Operation
- States: IDLE, RUN, FIX.
- IDLE, start=1 at an edge: accept the operation.
  - Latch the operand magnitudes: in signed mode, negative operands are negated; the magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), held as WIDTH-bit unsigned.
  - Latch neg = signed_mode & (a[MSB] ^ b[MSB]).
  - Clear the 2*WIDTH accumulator, set the iteration counter to 0, set busy=1, go to RUN.
- RUN: one iteration per edge.
  - If the multiplier LSB is 1, add the multiplicand, shifted left by the counter value, into the accumulator.
  - Shift the multiplier right by 1 and increment the counter.
  - After WIDTH iterations, go to FIX.
- FIX, single edge:
  - p <= neg ? (two's complement of accumulator) : accumulator.
  - done <= 1, busy <= 0, go to IDLE.
- The result is always exact, with no overflow. The extreme case is signed (-2^(W-1))·(-2^(W-1)) = 2^(2W-2), which still fits in 2W-bit signed.
- start in RUN or FIX is ignored; no queueing. Operand or mode changes after acceptance have no effect.
- p changes only on the FIX edge and on reset. During computation, p keeps the previous result.
- Counter width is clog2(WIDTH+1). The accumulator adder is 2*WIDTH bits wide, or narrower using the shift-right formulation with an identical result.

## Timing
- Reset: state=IDLE; p=0, busy=0, done=0; internal registers cleared.
- Reset mid-operation aborts immediately:
  - p is cleared to 0 (not held).
  - No done pulse follows.
  - The first edge after rst deasserts can accept a new start.
- Accept edge = edge 0. busy is high after edge 0 through edge WIDTH+1.
- Iterations occur on edges 1..WIDTH. FIX occurs on edge WIDTH+1: p is valid and done=1 for exactly one cycle following it.
- Latency, start-sample edge to done-high: WIDTH+1 clocks (5 for WIDTH=4).
- Back-to-back: start=1 during the done-high cycle (state is IDLE) is accepted on the next edge. Throughput is one product per WIDTH+1 cycles.
- start held high continuously produces back-to-back operations, each re-sampling a, b and signed_mode at its accept edge.
- done and busy are never high in the same cycle.

## Test plan
- WIDTH=4, unsigned, a=4'b1010, b=4'b0011, 1-cycle start → busy high for 5 cycles; done pulses once, 5 clocks after accept; p=8'h1E (30).
- WIDTH=8, three ops. Expected p:
  - signed a=8'h80, b=8'h80 → 16'h4000.
  - signed a=8'h80, b=8'h7F → 16'hC080 (-16256).
  - unsigned a=8'hFF, b=8'hFF → 16'hFE01.
- WIDTH=8, signed a=8'hFF, b=8'h01 → p=16'hFFFF. Then a=8'h00, b=8'h5A → p=16'h0000.
- Mid-operation start with a=3, b=3 while busy (first op a=5, b=7, unsigned) → ignored; exactly one done; p=35. p keeps the prior value until the FIX edge.
- Back-to-back: start asserted in the done-high cycle with a=2, b=9 → accepted; second done arrives exactly WIDTH+1 clocks later with p=18.
- rst asserted asynchronously (between edges) 3 cycles into an operation → p=0, busy=0, done=0 immediately; no done afterward. A start after release completes normally.
